// File: rtl/percep_pkg.sv
// rtl/percep_pkg.sv - shared sizes, sample limit and FSM encoding for the ydx reader
package percep_pkg;

    localparam int ATTR        = 5;
    localparam int X_WIDTH     = 16;
    localparam int MEM_WIDTH   = 17;
    localparam int MEM_ADDR    = 7;
    localparam int MAX_SAMPLES = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    function automatic logic [4:0] clamp_samples(input logic [4:0] n);
        return (n > 5'(MAX_SAMPLES)) ? 5'(MAX_SAMPLES) : n;
    endfunction

endpackage

// File: rtl/percep_ydx_reader_if.sv
// rtl/percep_ydx_reader_if.sv - dataset memory port and sample stream of the ydx reader
interface percep_ydx_reader_if #(
    parameter int MEM_WIDTH = percep_pkg::MEM_WIDTH,
    parameter int MEM_ADDR  = percep_pkg::MEM_ADDR,
    parameter int ATTR      = percep_pkg::ATTR,
    parameter int X_WIDTH   = percep_pkg::X_WIDTH
);
    logic                    mem_cs;
    logic                    mem_oe;
    logic                    mem_we;
    logic [MEM_ADDR-1:0]     mem_addr;
    logic [MEM_WIDTH-1:0]    mem_rdata;
    logic                    s_valid;
    logic                    s_ready;
    logic                    s_yd;
    logic [ATTR*X_WIDTH-1:0] s_x;

    modport master (
        output mem_cs, mem_oe, mem_we, mem_addr,
        input  mem_rdata,
        output s_valid, s_yd, s_x,
        input  s_ready
    );

    modport slave (
        input  mem_cs, mem_oe, mem_we, mem_addr,
        output mem_rdata,
        input  s_valid, s_yd, s_x,
        output s_ready
    );
endinterface

// File: rtl/percep_ydx_sbuf.sv
// rtl/percep_ydx_sbuf.sv - sample assembly register; shadow buffer when PERCEP_RD_PREFETCH_EN is defined
module percep_ydx_sbuf #(
    parameter int MEM_WIDTH = percep_pkg::MEM_WIDTH,
    parameter int ATTR      = percep_pkg::ATTR,
    parameter int X_WIDTH   = percep_pkg::X_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cap_en,
    input  logic [2:0]              row,
    input  logic [MEM_WIDTH-1:0]    rdata,
`ifdef PERCEP_RD_PREFETCH_EN
    input  logic                    load,
`endif
    output logic                    s_yd,
    output logic [ATTR*X_WIDTH-1:0] s_x
);
    import percep_pkg::*;

    logic [ATTR*X_WIDTH-1:0] asm_x, asm_x_next;
    logic                    asm_yd, asm_yd_next;

    // yd only ever comes from row 0 of a sample
    always_comb begin
        asm_x_next  = asm_x;
        asm_yd_next = asm_yd;
        if (cap_en) begin
            asm_x_next[row*X_WIDTH +: X_WIDTH] = rdata[X_WIDTH-1:0];
            if (row == 3'd0) begin
                asm_yd_next = rdata[MEM_WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_x  <= '0;
            asm_yd <= 1'b0;
        end else begin
            asm_x  <= asm_x_next;
            asm_yd <= asm_yd_next;
        end
    end

`ifdef PERCEP_RD_PREFETCH_EN
    // load may coincide with the last row capture, so it takes the post-capture view
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_x  <= '0;
            s_yd <= 1'b0;
        end else if (load) begin
            s_x  <= asm_x_next;
            s_yd <= asm_yd_next;
        end
    end
`else
    assign s_x  = asm_x;
    assign s_yd = asm_yd;
`endif

endmodule

// File: rtl/percep_ydx_reader.sv
// rtl/percep_ydx_reader.sv - streams (yd, x4..x0) samples out of dataset memory; PERCEP_RD_PREFETCH_EN adds prefetch
module percep_ydx_reader #(
    parameter int MEM_WIDTH = percep_pkg::MEM_WIDTH,
    parameter int MEM_ADDR  = percep_pkg::MEM_ADDR,
    parameter int ATTR      = percep_pkg::ATTR,
    parameter int X_WIDTH   = percep_pkg::X_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4:0]          n_sample,
    percep_ydx_reader_if.master bus,
    output logic                busy,
    output logic                done
);
    import percep_pkg::*;

    state_t                  state_q, state_d;
    logic [2:0]              row_q;
    logic [4:0]              cnt_q;
    logic [4:0]              idx_q;
    logic [4:0]              fidx_q;
    logic                    fetch_now, last_row, fetch_done, hs, more;
    logic [MEM_ADDR-1:0]     addr;
    logic                    s_yd_w;
    logic [ATTR*X_WIDTH-1:0] s_x_w;
`ifdef PERCEP_RD_PREFETCH_EN
    logic                    shadow_full_q;
    logic                    load;
`endif

    // idx_q counts delivered samples, fidx_q counts fully fetched ones
    always_comb begin
        fetch_now = (state_q == ST_FETCH);
`ifdef PERCEP_RD_PREFETCH_EN
        if (state_q == ST_HOLD && fidx_q != cnt_q && !shadow_full_q) begin
            fetch_now = 1'b1;
        end
`endif
        last_row   = (row_q == 3'(ATTR - 1));
        fetch_done = fetch_now && last_row;
        hs         = (state_q == ST_HOLD) && bus.s_ready;
        more       = (idx_q + 5'd1) != cnt_q;
    end

`ifdef PERCEP_RD_PREFETCH_EN
    assign load = (fetch_done && (state_q == ST_FETCH || hs)) || (hs && shadow_full_q);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (n_sample == 5'd0) ? ST_FIN : ST_FETCH;
            ST_FETCH: if (fetch_done) state_d = ST_HOLD;
            ST_HOLD: begin
                if (hs) begin
                    state_d = more ? ST_FETCH : ST_FIN;
`ifdef PERCEP_RD_PREFETCH_EN
                    if (shadow_full_q || fetch_done) state_d = ST_HOLD;
`endif
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            fidx_q  <= '0;
`ifdef PERCEP_RD_PREFETCH_EN
            shadow_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (start) begin
                    cnt_q  <= clamp_samples(n_sample);
                    idx_q  <= '0;
                    fidx_q <= '0;
                    row_q  <= '0;
`ifdef PERCEP_RD_PREFETCH_EN
                    shadow_full_q <= 1'b0;
`endif
                end
            end else begin
                if (fetch_now)  row_q  <= last_row ? 3'd0 : row_q + 3'd1;
                if (fetch_done) fidx_q <= fidx_q + 5'd1;
                if (hs)         idx_q  <= idx_q + 5'd1;
`ifdef PERCEP_RD_PREFETCH_EN
                if (state_q == ST_HOLD && fetch_done && !hs) shadow_full_q <= 1'b1;
                else if (hs)                                 shadow_full_q <= 1'b0;
`endif
            end
        end
    end

    assign addr = MEM_ADDR'(fidx_q) * MEM_ADDR'(ATTR) + MEM_ADDR'(row_q);

    assign bus.mem_cs   = fetch_now;
    assign bus.mem_oe   = fetch_now;
    assign bus.mem_we   = 1'b0;
    assign bus.mem_addr = fetch_now ? addr : '0;
    assign bus.s_valid  = (state_q == ST_HOLD);
    assign bus.s_yd     = s_yd_w;
    assign bus.s_x      = s_x_w;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FIN);

    percep_ydx_sbuf #(
        .MEM_WIDTH (MEM_WIDTH),
        .ATTR      (ATTR),
        .X_WIDTH   (X_WIDTH)
    ) u_sbuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_en (fetch_now),
        .row    (row_q),
        .rdata  (bus.mem_rdata),
`ifdef PERCEP_RD_PREFETCH_EN
        .load   (load),
`endif
        .s_yd   (s_yd_w),
        .s_x    (s_x_w)
    );

endmodule

// File: tb/tb_percep_ydx_reader.sv
// tb/tb_percep_ydx_reader.sv - randomized self-checking bench for percep_ydx_reader (honours PERCEP_RD_PREFETCH_EN)
module tb_percep_ydx_reader;
    import percep_pkg::*;

    localparam int XW = ATTR * X_WIDTH;
`ifdef PERCEP_RD_PREFETCH_EN
    localparam int GAP = 5;
`else
    localparam int GAP = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] n_sample = 5'd0;
    logic       busy, done;

    percep_ydx_reader_if bus_if ();

    percep_ydx_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_sample (n_sample),
        .bus      (bus_if),
        .busy     (busy),
        .done     (done)
    );

    logic [MEM_WIDTH-1:0] mem [0:127];
    assign bus_if.mem_rdata = mem[bus_if.mem_addr];

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) mem[i] = MEM_WIDTH'($urandom);
    endtask

    function automatic logic [127:0] all_outputs();
        return {34'd0, bus_if.s_valid, bus_if.s_yd, bus_if.s_x, busy, done,
                bus_if.mem_cs, bus_if.mem_oe, bus_if.mem_we, bus_if.mem_addr};
    endfunction

    // mode 0: ready always high, 1: ready held low 10 valid cycles per sample, 2: random ready and start noise
    task automatic run_pass(input int n, input int mode, input int abort_addr);
        logic [XW:0]   exp_q[$];
        logic [XW-1:0] x;
        int cnt, a_exp, hs_cnt, last_hs, stall_left;
        bit seen_done;
        cnt = (n > MAX_SAMPLES) ? MAX_SAMPLES : n;
        for (int s = 0; s < cnt; s++) begin
            x = '0;
            for (int r = 0; r < ATTR; r++) x[r*X_WIDTH +: X_WIDTH] = mem[s*ATTR + r][X_WIDTH-1:0];
            exp_q.push_back({mem[s*ATTR][MEM_WIDTH-1], x});
        end
        a_exp = 0; hs_cnt = 0; last_hs = 0; stall_left = 10; seen_done = 0;
        @(negedge clk);
        start = 1'b1;
        n_sample = 5'(n);
        bus_if.s_ready = 1'b0;
        for (int k = 1; k <= 3000 && !seen_done; k++) begin
            @(negedge clk);
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            n_sample = 5'($urandom_range(0, 31));
            case (mode)
                0:       bus_if.s_ready = 1'b1;
                1:       bus_if.s_ready = (stall_left == 0);
                default: bus_if.s_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("mem_we", bus_if.mem_we, 0);
            if (bus_if.mem_cs) begin
                check("mem_addr", bus_if.mem_addr, a_exp);
                check("mem_oe", bus_if.mem_oe, 1);
                check("fetch_in_range", a_exp < ATTR * cnt, 1);
                if (abort_addr >= 0 && int'(bus_if.mem_addr) == abort_addr) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    #1;
                    check("reset_mid_pass", all_outputs(), 0);
                    rst_n = 1'b1;
                    start = 1'b0;
                    return;
                end
                a_exp++;
            end
            if (bus_if.s_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_sample", 1, 0);
                end else begin
                    check("sample", {bus_if.s_yd, bus_if.s_x}, exp_q[0]);
                    if (bus_if.s_ready) begin
                        if (mode == 0) check("hs_timing", k, (hs_cnt == 0) ? 6 : last_hs + GAP);
                        hs_cnt++;
                        last_hs = k;
                        void'(exp_q.pop_front());
                        stall_left = 10;
                    end else if (stall_left > 0) begin
                        stall_left--;
                    end
                end
            end
            if (done) begin
                seen_done = 1;
                check("done_timing", k, (cnt == 0) ? 1 : last_hs + 1);
                check("sample_count", hs_cnt, cnt);
                check("addr_count", a_exp, ATTR * cnt);
            end
            check("busy_in_pass", busy, 1);
        end
        if (!seen_done) check("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        fill_mem();
        bus_if.s_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;

        mem[0] = 17'h1_0001;
        mem[1] = 17'h0_0002;
        mem[2] = 17'h1_0003;
        mem[3] = 17'h0_0004;
        mem[4] = 17'h0_0005;
        run_pass(1, 0, -1);

        fill_mem();
        run_pass(3, 1, -1);
        run_pass(0, 0, -1);
        run_pass(31, 0, -1);
        run_pass(3, 0, 11);
        run_pass(2, 0, -1);
        run_pass(4, 0, -1);

        repeat (6) begin
            fill_mem();
            run_pass(int'($urandom_range(0, 31)), int'($urandom_range(1, 2)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
